// File: rtl/doorlock_seg_pkg.sv
// Shared definitions for the doorlock 7-segment message driver:
// glyph codes (active-low {g,f,e,d,c,b,a}), message ids, display state
// and the message ROM helper functions.
package doorlock_seg_pkg;

    // Glyphs, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_O     = 7'h40;
    localparam logic [6:0] G_P     = 7'h0C;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_N     = 7'h2B;
    localparam logic [6:0] G_C     = 7'h46;
    localparam logic [6:0] G_L     = 7'h47;
    localparam logic [6:0] G_S     = 7'h12;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_R     = 7'h2F;
    localparam logic [6:0] G_A     = 7'h08;
    localparam logic [6:0] G_B     = 7'h03;
    localparam logic [6:0] G_I     = 7'h79;
    localparam logic [6:0] G_T     = 7'h07;
    localparam logic [6:0] G_U     = 7'h41;
    localparam logic [6:0] G_H     = 7'h09;

    // Message ids
    localparam logic [2:0] MSG_IDLE   = 3'd0;
    localparam logic [2:0] MSG_OPEN   = 3'd1;
    localparam logic [2:0] MSG_CLOSED = 3'd2;
    localparam logic [2:0] MSG_ERR    = 3'd3;
    localparam logic [2:0] MSG_ENTER  = 3'd4;
    localparam logic [2:0] MSG_BAD    = 3'd5;

    typedef enum logic {
        S_STATIC = 1'b0,
        S_SCROLL = 1'b1
    } state_e;

    // Character count of a message. Fill-only messages (idle, blank ids)
    // have length 0 so every digit shows the fill glyph.
    function automatic logic [3:0] msg_len(input logic [2:0] id);
        logic [3:0] len;
        case (id)
            MSG_OPEN:   len = 4'd4;
            MSG_CLOSED: len = 4'd6;
            MSG_ERR:    len = 4'd3;
            MSG_ENTER:  len = 4'd9;
            MSG_BAD:    len = 4'd7;
            default:    len = 4'd0;
        endcase
        return len;
    endfunction

    // Only the error message carries the blink attribute.
    function automatic logic msg_blink(input logic [2:0] id);
        return (id == MSG_ERR);
    endfunction

    // Glyph shown on digits not covered by a character.
    function automatic logic [6:0] msg_fill(input logic [2:0] id);
        return (id == MSG_IDLE) ? G_DASH : G_BLANK;
    endfunction

    // Message ROM: character idx of message id; out-of-range gives fill.
    function automatic logic [6:0] msg_glyph(input logic [2:0] id, input logic [3:0] idx);
        logic [6:0] g;
        case ({id, idx})
            {MSG_OPEN,   4'd0}: g = G_O;
            {MSG_OPEN,   4'd1}: g = G_P;
            {MSG_OPEN,   4'd2}: g = G_E;
            {MSG_OPEN,   4'd3}: g = G_N;
            {MSG_CLOSED, 4'd0}: g = G_C;
            {MSG_CLOSED, 4'd1}: g = G_L;
            {MSG_CLOSED, 4'd2}: g = G_O;
            {MSG_CLOSED, 4'd3}: g = G_S;
            {MSG_CLOSED, 4'd4}: g = G_E;
            {MSG_CLOSED, 4'd5}: g = G_D;
            {MSG_ERR,    4'd0}: g = G_E;
            {MSG_ERR,    4'd1}: g = G_R;
            {MSG_ERR,    4'd2}: g = G_R;
            {MSG_ENTER,  4'd0}: g = G_E;
            {MSG_ENTER,  4'd1}: g = G_N;
            {MSG_ENTER,  4'd2}: g = G_T;
            {MSG_ENTER,  4'd3}: g = G_E;
            {MSG_ENTER,  4'd4}: g = G_R;
            {MSG_ENTER,  4'd5}: g = G_BLANK;
            {MSG_ENTER,  4'd6}: g = G_P;
            {MSG_ENTER,  4'd7}: g = G_I;
            {MSG_ENTER,  4'd8}: g = G_N;
            {MSG_BAD,    4'd0}: g = G_B;
            {MSG_BAD,    4'd1}: g = G_A;
            {MSG_BAD,    4'd2}: g = G_D;
            {MSG_BAD,    4'd3}: g = G_BLANK;
            {MSG_BAD,    4'd4}: g = G_P;
            {MSG_BAD,    4'd5}: g = G_I;
            {MSG_BAD,    4'd6}: g = G_N;
            default:            g = msg_fill(id);
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Modulo-N tick divider: counts 0..N-1 while enabled, tick_o is high
// during the terminal-count cycle; clr_i restarts the count at 0.
module seg_tick_div #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int             W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]   TC = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == TC);

    // Next count: clear wins, otherwise wrap at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == TC) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_msg_display.sv
// Multi-digit 7-segment message driver. Short messages are right-aligned,
// long ones scroll left with one trailing blank. All outputs are registered
// and computed from next-state values, so a load is visible one cycle later.
// Optional feature macro: DOORLOCK_SEG_BLINK_EN (blinking error message).
module seg_msg_display
    import doorlock_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int BLINK_DIV  = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_load,
    input  logic [2:0]              msg_sel,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    scrolling,
    output logic                    wrap_pulse
);

    localparam logic [3:0] ND4 = 4'(NUM_DIGITS);

    logic [2:0]              msg_q, msg_d;
    state_e                  state_q, state_d;
    logic [3:0]              offset_q, offset_d;
    logic                    wrap_q, wrap_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                    scrolling_q, scrolling_d;
    logic                    scroll_tick_s;
    logic                    show_d_s;
    logic [4:0]              period_q_s;
    logic [3:0]              len_d_s;
    logic [4:0]              period_d_s;
    logic [3:0]              lead_s;
    logic [4:0]              sum_s;
    logic [6:0]              glyph_s;

    seg_tick_div #(.N(SCROLL_DIV)) u_scroll_div (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (msg_load),
        .en_i   (state_q == S_SCROLL),
        .tick_o (scroll_tick_s)
    );

`ifdef DOORLOCK_SEG_BLINK_EN
    logic vis_q, vis_d;
    logic blink_tick_s;

    seg_tick_div #(.N(BLINK_DIV)) u_blink_div (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (msg_load),
        .en_i   (msg_blink(msg_q)),
        .tick_o (blink_tick_s)
    );

    // Blink phase: visible after a load, toggles on each blink tick
    always_comb begin
        vis_d = vis_q;
        if (msg_load) begin
            vis_d = 1'b1;
        end else if (blink_tick_s) begin
            vis_d = ~vis_q;
        end else begin
            vis_d = vis_q;
        end
    end

    assign show_d_s = vis_d;

    // Blink phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            vis_q <= 1'b1;
        end else begin
            vis_q <= vis_d;
        end
    end
`else
    assign show_d_s = 1'b1;
`endif

    assign period_q_s = {1'b0, msg_len(msg_q)} + 5'd1;

    // Message/state/offset next state; a load discards any coincident tick
    always_comb begin
        msg_d   = msg_q;
        state_d = state_q;
        offset_d = offset_q;
        wrap_d  = 1'b0;
        if (msg_load) begin
            msg_d    = msg_sel;
            offset_d = 4'd0;
            state_d  = (msg_len(msg_sel) > ND4) ? S_SCROLL : S_STATIC;
        end else if ((state_q == S_SCROLL) && scroll_tick_s) begin
            if ({1'b0, offset_q} == (period_q_s - 5'd1)) begin
                offset_d = 4'd0;
                wrap_d   = 1'b1;
            end else begin
                offset_d = offset_q + 4'd1;
            end
        end else begin
            offset_d = offset_q;
        end
    end

    // Render the next display contents from the next-state values
    always_comb begin
        seg_d      = '0;
        glyph_s    = G_BLANK;
        sum_s      = 5'd0;
        len_d_s    = msg_len(msg_d);
        period_d_s = {1'b0, len_d_s} + 5'd1;
        lead_s     = ND4 - len_d_s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_d == S_SCROLL) begin
                sum_s = {1'b0, offset_d} + 5'(i);
                if (sum_s >= period_d_s) begin
                    sum_s = sum_s - period_d_s;
                end else begin
                    sum_s = sum_s;
                end
                glyph_s = msg_glyph(msg_d, sum_s[3:0]);
            end else begin
                if (4'(i) >= lead_s) begin
                    glyph_s = msg_glyph(msg_d, 4'(i) - lead_s);
                end else begin
                    glyph_s = msg_fill(msg_d);
                end
            end
            if (!show_d_s) begin
                glyph_s = G_BLANK;
            end else begin
                glyph_s = glyph_s;
            end
            seg_d[7*(NUM_DIGITS-1-i) +: 7] = glyph_s;
        end
        scrolling_d = (state_d == S_SCROLL);
    end

    // State and registered outputs; reset beats load
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_q       <= MSG_IDLE;
            state_q     <= S_STATIC;
            offset_q    <= 4'd0;
            wrap_q      <= 1'b0;
            seg_q       <= {NUM_DIGITS{G_DASH}};
            scrolling_q <= 1'b0;
        end else begin
            msg_q       <= msg_d;
            state_q     <= state_d;
            offset_q    <= offset_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
            scrolling_q <= scrolling_d;
        end
    end

    assign seg_out    = seg_q;
    assign scrolling  = scrolling_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_seg_msg_display.sv
// Scoreboard bench for seg_msg_display (NUM_DIGITS=6, SCROLL_DIV=4, BLINK_DIV=8).
module tb_seg_msg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_load = 1'b0;
    logic [2:0]  msg_sel = 3'd0;
    logic [41:0] seg_out;
    logic        scrolling;
    logic        wrap_pulse;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int base;

    typedef struct {
        int          cyc;
        logic [41:0] seg;
        logic        scr;
        logic        wrp;
    } exp_t;
    exp_t sbq[$];

    // Hand-written virtual scroll strings (message + trailing blank)
    logic [6:0] vs4 [10] = '{7'h06, 7'h2B, 7'h07, 7'h06, 7'h2F, 7'h7F, 7'h0C, 7'h79, 7'h2B, 7'h7F};
    logic [6:0] vs5 [8]  = '{7'h03, 7'h08, 7'h21, 7'h7F, 7'h0C, 7'h79, 7'h2B, 7'h7F};

    localparam logic [41:0] DASH6  = {6{7'h3F}};
    localparam logic [41:0] BLANK6 = {6{7'h7F}};
    localparam logic [41:0] OPEN6  = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
    localparam logic [41:0] CLOSE6 = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
    localparam logic [41:0] ERR6   = {7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F};

    seg_msg_display #(
        .NUM_DIGITS (6),
        .SCROLL_DIV (4),
        .BLINK_DIV  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_load   (msg_load),
        .msg_sel    (msg_sel),
        .seg_out    (seg_out),
        .scrolling  (scrolling),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [41:0] win4(input int off);
        logic [41:0] v;
        for (int k = 0; k < 6; k++) v[7*(5-k) +: 7] = vs4[(off + k) % 10];
        return v;
    endfunction

    function automatic logic [41:0] win5(input int off);
        logic [41:0] v;
        for (int k = 0; k < 6; k++) v[7*(5-k) +: 7] = vs5[(off + k) % 8];
        return v;
    endfunction

    task automatic push(input int c, input logic [41:0] s, input logic scr, input logic w);
        exp_t e;
        e.cyc = c; e.seg = s; e.scr = scr; e.wrp = w;
        sbq.push_back(e);
    endtask

    task automatic start_load(input logic [2:0] id);
        msg_load = 1'b1;
        msg_sel  = id;
        base     = cyc + 1;
    endtask

    task automatic run_until(input int target);
        @(negedge clk);
        msg_load = 1'b0;
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            n_total++;
            if (e.cyc < cyc) begin
                $display("FAIL stale_expect cyc=%0d got_cyc=%0d required_cyc=%0d", cyc, cyc, e.cyc);
            end else if (seg_out !== e.seg || scrolling !== e.scr || wrap_pulse !== e.wrp) begin
                $display("FAIL display cyc=%0d got seg=%h scr=%b wrap=%b required seg=%h scr=%b wrap=%b",
                         cyc, seg_out, scrolling, wrap_pulse, e.seg, e.scr, e.wrp);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        // Reset, then idle with no load
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) push(cyc + j, DASH6, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // Short messages, right-aligned and steady
        start_load(3'd1);
        for (int j = 0; j < 20; j++) push(base + j, OPEN6, 1'b0, 1'b0);
        run_until(base + 19);
        start_load(3'd2);
        for (int j = 0; j < 100; j++) push(base + j, CLOSE6, 1'b0, 1'b0);
        run_until(base + 99);
        start_load(3'd0);
        for (int j = 0; j < 5; j++) push(base + j, DASH6, 1'b0, 1'b0);
        run_until(base + 4);
        start_load(3'd6);
        for (int j = 0; j < 5; j++) push(base + j, BLANK6, 1'b0, 1'b0);
        run_until(base + 4);
        start_load(3'd7);
        for (int j = 0; j < 5; j++) push(base + j, BLANK6, 1'b0, 1'b0);
        run_until(base + 4);

        // Error message: blinks only with the feature macro
        start_load(3'd3);
        for (int j = 0; j < 40; j++) begin
`ifdef DOORLOCK_SEG_BLINK_EN
            push(base + j, (((j / 8) % 2) == 0) ? ERR6 : BLANK6, 1'b0, 1'b0);
`else
            push(base + j, ERR6, 1'b0, 1'b0);
`endif
        end
        run_until(base + 39);

        // Long message scrolls; two wraps; reload at a scroll tick (j=87)
        start_load(3'd4);
        for (int j = 0; j <= 87; j++)
            push(base + j, win4((j / 4) % 10), 1'b1, (j > 0) && (j % 40 == 0));
        run_until(base + 87);
        start_load(3'd5);
        for (int j = 0; j <= 31; j++)
            push(base + j, win5((j / 4) % 8), 1'b1, 1'b0);
        run_until(base + 31);

        // Reset together with a load right before a scroll wrap
        rst = 1'b1;
        msg_load = 1'b1;
        msg_sel = 3'd2;
        base = cyc + 1;
        for (int j = 0; j < 6; j++) push(base + j, DASH6, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        msg_load = 1'b0;
        while (cyc < base + 5) @(negedge clk);

        repeat (2) @(negedge clk);
        n_total++;
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain got=%0d required=0", sbq.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
